// File: rtl/layer_pkg.sv
// Shared types and constants for the layer parameter loader: FSM state encoding,
// default layer geometry with derived frame section lengths, and the mask LFSR taps.
package layer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_B,
        ST_LOAD_W,
        ST_LOAD_X,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam int DEF_INPUT_SIZE  = 10;
    localparam int DEF_OUTPUT_SIZE = 10;
    localparam int DEF_WIDTH       = 16;

    localparam int N_B     = DEF_OUTPUT_SIZE;
    localparam int N_W     = DEF_OUTPUT_SIZE * DEF_INPUT_SIZE;
    localparam int N_X     = DEF_INPUT_SIZE;
    localparam int N_TOTAL = N_B + N_W + N_X;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right-shifting register)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int frame_len(input int os, input int is);
        return os + os * is + is;
    endfunction

endpackage

// File: rtl/mask_lfsr.sv
// Galois LFSR producing the per-word mask for input share splitting.
// Loaded with a seed at frame start (zero seed forced to 1), steps once per request.
module mask_lfsr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] lfsr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= WIDTH'(1);
        end else if (load) begin
            lfsr_reg <= (seed == '0) ? WIDTH'(1) : seed;
        end else if (step) begin
            lfsr_reg <= (lfsr_reg >> 1) ^ (lfsr_reg[0] ? TAPS : '0);
        end
    end

    assign value = lfsr_reg;

endmodule

// File: rtl/layer_param_loader.sv
// Streams bias, weight and input words into parallel register banks for the NN layer.
// Optional MASK_SHARE_EN stores inputs as an additive share pair (x - m, m).
module layer_param_loader
    import layer_pkg::*;
#(
    parameter int INPUT_SIZE  = DEF_INPUT_SIZE,
    parameter int OUTPUT_SIZE = DEF_OUTPUT_SIZE,
    parameter int WIDTH       = DEF_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [WIDTH-1:0]                       s_data,
    input  logic                                   s_last,
    output logic [OUTPUT_SIZE*WIDTH-1:0]           b_flat,
    output logic [OUTPUT_SIZE*INPUT_SIZE*WIDTH-1:0] w_flat,
    output logic [INPUT_SIZE*WIDTH-1:0]            x_flat,
`ifdef MASK_SHARE_EN
    input  logic [WIDTH-1:0]                       mask_seed,
    output logic [INPUT_SIZE*WIDTH-1:0]            x_mask_flat,
`endif
    output logic                                   params_valid,
    input  logic                                   layer_ack,
    output logic                                   err
);

    localparam int MAXS = (OUTPUT_SIZE > INPUT_SIZE) ? OUTPUT_SIZE : INPUT_SIZE;
    localparam int CW   = $clog2(MAXS + 1);
    localparam int RW   = $clog2(OUTPUT_SIZE + 1);
    localparam int CLW  = $clog2(INPUT_SIZE + 1);

    loader_state_t    state_reg;
    logic             s_ready_reg, pv_reg, err_reg;
    logic [CW-1:0]    sec_cnt_reg;
    logic [RW-1:0]    row_reg;
    logic [CLW-1:0]   col_reg;
    logic             xfer, begin_frame, wr_b, wr_w, wr_x;
    logic [WIDTH-1:0] x_store;

    assign xfer        = s_valid & s_ready_reg;
    assign begin_frame = start & ((state_reg == ST_IDLE) | (state_reg == ST_ERR));
    assign wr_b        = xfer & (state_reg == ST_LOAD_B);
    assign wr_w        = xfer & (state_reg == ST_LOAD_W);
    assign wr_x        = xfer & (state_reg == ST_LOAD_X);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            s_ready_reg <= 1'b0;
            pv_reg      <= 1'b0;
            err_reg     <= 1'b0;
            sec_cnt_reg <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_ERR: begin
                    if (begin_frame) begin
                        state_reg   <= ST_LOAD_B;
                        s_ready_reg <= 1'b1;
                        err_reg     <= 1'b0;
                        sec_cnt_reg <= '0;
                        row_reg     <= '0;
                        col_reg     <= '0;
                    end
                end
                ST_LOAD_B: begin
                    if (xfer) begin
                        if (s_last) begin
                            state_reg   <= ST_ERR;
                            s_ready_reg <= 1'b0;
                            err_reg     <= 1'b1;
                        end else if (sec_cnt_reg == CW'(OUTPUT_SIZE - 1)) begin
                            sec_cnt_reg <= '0;
                            state_reg   <= ST_LOAD_W;
                        end else begin
                            sec_cnt_reg <= sec_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (xfer) begin
                        if (s_last) begin
                            state_reg   <= ST_ERR;
                            s_ready_reg <= 1'b0;
                            err_reg     <= 1'b1;
                        end else if (col_reg == CLW'(INPUT_SIZE - 1)) begin
                            col_reg <= '0;
                            if (row_reg == RW'(OUTPUT_SIZE - 1)) begin
                                row_reg   <= '0;
                                state_reg <= ST_LOAD_X;
                            end else begin
                                row_reg <= row_reg + 1'b1;
                            end
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                ST_LOAD_X: begin
                    if (xfer) begin
                        // Only the very last word of the frame may carry s_last
                        if (sec_cnt_reg == CW'(INPUT_SIZE - 1)) begin
                            sec_cnt_reg <= '0;
                            s_ready_reg <= 1'b0;
                            if (s_last) begin
                                state_reg <= ST_DONE;
                                pv_reg    <= 1'b1;
                            end else begin
                                state_reg <= ST_ERR;
                                err_reg   <= 1'b1;
                            end
                        end else if (s_last) begin
                            state_reg   <= ST_ERR;
                            s_ready_reg <= 1'b0;
                            err_reg     <= 1'b1;
                        end else begin
                            sec_cnt_reg <= sec_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (layer_ack) begin
                        state_reg <= ST_IDLE;
                        pv_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    s_ready_reg <= 1'b0;
                    pv_reg      <= 1'b0;
                    err_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready      = s_ready_reg;
    assign params_valid = pv_reg;
    assign err          = err_reg;

`ifdef MASK_SHARE_EN
    logic [WIDTH-1:0] mask_val;

    mask_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (WIDTH'(LFSR_TAPS))
    ) u_mask_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (begin_frame),
        .seed  (mask_seed),
        .step  (wr_x),
        .value (mask_val)
    );

    assign x_store = s_data - mask_val;
`else
    assign x_store = s_data;
`endif

    // One register per bank slot, enabled when its section index matches
    genvar gi, gj;
    generate
        for (gi = 0; gi < OUTPUT_SIZE; gi++) begin : g_bias
            logic [WIDTH-1:0] slot_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                                  slot_reg <= '0;
                else if (wr_b && sec_cnt_reg == CW'(gi))     slot_reg <= s_data;
            end
            assign b_flat[gi*WIDTH +: WIDTH] = slot_reg;
        end

        for (gi = 0; gi < OUTPUT_SIZE; gi++) begin : g_wrow
            for (gj = 0; gj < INPUT_SIZE; gj++) begin : g_wcol
                logic [WIDTH-1:0] slot_reg;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) slot_reg <= '0;
                    else if (wr_w && row_reg == RW'(gi) && col_reg == CLW'(gj))
                        slot_reg <= s_data;
                end
                assign w_flat[(gi*INPUT_SIZE+gj)*WIDTH +: WIDTH] = slot_reg;
            end
        end

        for (gi = 0; gi < INPUT_SIZE; gi++) begin : g_x
            logic [WIDTH-1:0] slot_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                                  slot_reg <= '0;
                else if (wr_x && sec_cnt_reg == CW'(gi))     slot_reg <= x_store;
            end
            assign x_flat[gi*WIDTH +: WIDTH] = slot_reg;
`ifdef MASK_SHARE_EN
            logic [WIDTH-1:0] mask_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                                  mask_reg <= '0;
                else if (wr_x && sec_cnt_reg == CW'(gi))     mask_reg <= mask_val;
            end
            assign x_mask_flat[gi*WIDTH +: WIDTH] = mask_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_layer_param_loader.sv
// Directed self-checking bench for layer_param_loader (default 10x10x16 geometry);
// the mask scenario is compiled in when MASK_SHARE_EN is defined.
module tb_layer_param_loader;

    localparam int IS = 10;
    localparam int OS = 10;
    localparam int W  = 16;
    localparam int NT = OS + OS * IS + IS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [W-1:0]      s_data = '0;
    logic              s_last = 1'b0;
    logic [OS*W-1:0]   b_flat;
    logic [OS*IS*W-1:0] w_flat;
    logic [IS*W-1:0]   x_flat;
    logic              params_valid;
    logic              layer_ack = 1'b0;
    logic              err;
`ifdef MASK_SHARE_EN
    logic [W-1:0]      mask_seed = '0;
    logic [IS*W-1:0]   x_mask_flat;
`endif

    int checks = 0;
    int failures = 0;

    layer_param_loader #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .b_flat       (b_flat),
        .w_flat       (w_flat),
        .x_flat       (x_flat),
`ifdef MASK_SHARE_EN
        .mask_seed    (mask_seed),
        .x_mask_flat  (x_mask_flat),
`endif
        .params_valid (params_valid),
        .layer_ack    (layer_ack),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] get_b(input int k);
        return b_flat[k*W +: W];
    endfunction

    function automatic logic [W-1:0] get_w(input int o, input int i);
        return w_flat[(o*IS+i)*W +: W];
    endfunction

    // Reconstructed input value (share sum when masking is built in)
    function automatic logic [W-1:0] get_x(input int i);
`ifdef MASK_SHARE_EN
        return x_flat[i*W +: W] + x_mask_flat[i*W +: W];
`else
        return x_flat[i*W +: W];
`endif
    endfunction

    function automatic logic [W-1:0] get_word(input int k);
        if (k < OS)           return get_b(k);
        else if (k < OS+OS*IS) return get_w((k-OS)/IS, (k-OS)%IS);
        else                  return get_x(k-OS-OS*IS);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_ack();
        layer_ack = 1'b1;
        step();
        layer_ack = 1'b0;
    endtask

    // Push nwords words (data = k + base, or 0x1234 for inputs when const_x)
    task automatic drive_words(input int nwords, input int last_at, input bit rnd,
                               input logic [W-1:0] base, input bit const_x,
                               output int ready_cycles);
        int k = 0;
        int budget = 0;
        logic rdy;
        ready_cycles = 0;
        while (k < nwords && budget < nwords * 4 + 40) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = (const_x && k >= NT - IS) ? 16'h1234 : W'(k) + base;
            s_last  = (k == last_at);
            rdy = s_ready;
            if (rdy) ready_cycles++;
            step();
            budget++;
            if (s_valid && rdy) k++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        checks++;
        if (k != nwords) begin
            failures++;
            $display("FAIL drive_words: accepted=%0d required=%0d", k, nwords);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({s_ready, params_valid, err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got=%b required=000", {s_ready, params_valid, err});
        end
        checks++;
        if (b_flat !== '0 || w_flat !== '0 || x_flat !== '0) begin
            failures++;
            $display("FAIL reset_banks: banks nonzero, required all 0");
        end
        rst_n = 1'b1;
        step();
        $display("reset: released");
    endtask

    task automatic test_full_frame();
        int rc;
        int bad = 0;
        do_start();
        drive_words(NT, NT-1, 1'b0, '0, 1'b0, rc);
        checks++;
        if (rc != NT) begin
            failures++;
            $display("FAIL ready_cycles: got=%0d required=%0d", rc, NT);
        end
        checks++;
        if ({params_valid, s_ready, err} !== 3'b100) begin
            failures++;
            $display("FAIL full_done_flags: got=%b required=100", {params_valid, s_ready, err});
        end
        checks++;
        if (get_b(3) !== 16'd3) begin
            failures++;
            $display("FAIL b3: got=%0d required=3", get_b(3));
        end
        checks++;
        if (get_w(2, 5) !== 16'd35) begin
            failures++;
            $display("FAIL w2_5: got=%0d required=35", get_w(2, 5));
        end
        checks++;
        if (get_x(9) !== 16'd119) begin
            failures++;
            $display("FAIL x9: got=%0d required=119", get_x(9));
        end
        for (int k = 0; k < NT; k++) if (get_word(k) !== W'(k)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL full_scan: bad_slots=%0d required=0", bad);
        end
        do_start();
        checks++;
        if ({params_valid, s_ready} !== 2'b10) begin
            failures++;
            $display("FAIL done_start_ignored: got=%b required=10", {params_valid, s_ready});
        end
        do_ack();
        checks++;
        if (params_valid !== 1'b0 || get_w(2, 5) !== 16'd35) begin
            failures++;
            $display("FAIL ack_retain: pv=%b w2_5=%0d required pv=0 w2_5=35", params_valid, get_w(2, 5));
        end
        $display("full_frame: loaded %0d words", NT);
    endtask

    task automatic test_back_to_back();
        int rc;
        int bad = 0;
        do_start();
        drive_words(NT, NT-1, 1'b1, 16'h0100, 1'b0, rc);
        checks++;
        if (params_valid !== 1'b1) begin
            failures++;
            $display("FAIL toggle_pv: got=%b required=1", params_valid);
        end
        for (int k = 0; k < NT; k++) if (get_word(k) !== W'(k) + 16'h0100) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL toggle_scan: bad_slots=%0d required=0", bad);
        end
        do_ack();
        $display("back_to_back: toggled valid, ready_cycles=%0d", rc);
    endtask

    task automatic test_early_last();
        int rc;
        do_start();
        drive_words(51, 50, 1'b0, 16'h0200, 1'b0, rc);
        checks++;
        if ({err, params_valid, s_ready} !== 3'b100) begin
            failures++;
            $display("FAIL early_last_flags: got=%b required=100", {err, params_valid, s_ready});
        end
        checks++;
        if (get_w(4, 0) !== 16'h0200 + 16'd50) begin
            failures++;
            $display("FAIL early_last_word: got=%h required=%h", get_w(4, 0), 16'h0232);
        end
        do_start();
        checks++;
        if ({err, s_ready} !== 2'b01) begin
            failures++;
            $display("FAIL err_restart: got=%b required=01", {err, s_ready});
        end
        drive_words(NT, NT-1, 1'b0, '0, 1'b0, rc);
        checks++;
        if (params_valid !== 1'b1 || get_x(9) !== 16'd119 || get_w(4, 0) !== 16'd50) begin
            failures++;
            $display("FAIL reload: pv=%b x9=%0d w4_0=%0d required 1/119/50", params_valid, get_x(9), get_w(4, 0));
        end
        do_ack();
        $display("early_last: err raised and cleared by restart");
    endtask

    task automatic test_missing_last();
        int rc;
        do_start();
        drive_words(NT, -1, 1'b0, 16'h0300, 1'b0, rc);
        checks++;
        if ({err, params_valid, s_ready} !== 3'b100) begin
            failures++;
            $display("FAIL missing_last_flags: got=%b required=100", {err, params_valid, s_ready});
        end
        checks++;
        if (get_x(9) !== 16'h0300 + 16'd119) begin
            failures++;
            $display("FAIL missing_last_word: got=%h required=%h", get_x(9), 16'h0377);
        end
        do_ack();
        checks++;
        if ({err, params_valid, s_ready} !== 3'b100) begin
            failures++;
            $display("FAIL ack_in_err: got=%b required=100", {err, params_valid, s_ready});
        end
        $display("missing_last: err sticky through layer_ack");
    endtask

    task automatic test_midframe_reset();
        int rc;
        do_start();
        drive_words(60, -1, 1'b0, 16'h0400, 1'b0, rc);
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL midframe_loading: s_ready=%b required=1", s_ready);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({s_ready, params_valid, err} !== 3'b000 || b_flat !== '0 || w_flat !== '0 || x_flat !== '0) begin
            failures++;
            $display("FAIL async_reset: flags=%b banks_zero=%b required 000/1", {s_ready, params_valid, err},
                     (b_flat == '0 && w_flat == '0 && x_flat == '0));
        end
        #1;
        rst_n = 1'b1;
        step();
        do_start();
        drive_words(NT, NT-1, 1'b0, 16'h0500, 1'b0, rc);
        checks++;
        if (params_valid !== 1'b1 || get_w(9, 9) !== 16'h0500 + 16'd109 || get_b(0) !== 16'h0500) begin
            failures++;
            $display("FAIL post_reset_load: pv=%b w9_9=%h b0=%h required 1/056d/0500", params_valid, get_w(9, 9), get_b(0));
        end
        do_ack();
        $display("midframe_reset: frame aborted and reloaded");
    endtask

`ifdef MASK_SHARE_EN
    task automatic test_mask();
        int rc;
        int bad = 0;
        int dup = 0;
        logic [IS*W-1:0] x_saved;
        mask_seed = 16'hACE1;
        do_start();
        drive_words(NT, NT-1, 1'b0, '0, 1'b1, rc);
        checks++;
        if (x_mask_flat[0 +: W] !== 16'hACE1) begin
            failures++;
            $display("FAIL mask_first: got=%h required=ace1", x_mask_flat[0 +: W]);
        end
        for (int i = 0; i < IS; i++)
            if (W'(x_flat[i*W +: W] + x_mask_flat[i*W +: W]) !== 16'h1234) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mask_sum: bad_slots=%0d required=0", bad);
        end
        for (int i = 0; i < IS; i++)
            for (int j = i + 1; j < IS; j++)
                if (x_mask_flat[i*W +: W] === x_mask_flat[j*W +: W]) dup++;
        checks++;
        if (dup != 0) begin
            failures++;
            $display("FAIL mask_distinct: equal_pairs=%0d required=0", dup);
        end
        x_saved = x_flat;
        do_ack();
        checks++;
        if (params_valid !== 1'b0 || x_flat !== x_saved) begin
            failures++;
            $display("FAIL mask_ack_retain: pv=%b x_changed=%b required 0/0", params_valid, (x_flat != x_saved));
        end
        $display("mask: shares checked for %0d inputs", IS);
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_early_last();
        test_missing_last();
        test_midframe_reset();
`ifdef MASK_SHARE_EN
        test_mask();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
